// File: rtl/pipe_div_ctrl_pkg.sv
// pipe_div_ctrl_pkg: stall encodings, divider FSM states and widths shared by the pipeline controller.
package pipe_div_ctrl_pkg;
  localparam int STALL_BUS = 5;
  localparam int CNT_W = 32;
  localparam logic [STALL_BUS-1:0] STALL_NONE = 5'b00000;
  localparam logic [STALL_BUS-1:0] STALL_ID = 5'b00011;
  localparam logic [STALL_BUS-1:0] STALL_EXE = 5'b00111;
  localparam logic [63:0] ZERO_DWORD = 64'h0;
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;
endpackage

// File: rtl/pipe_div_ctrl_stall_perf_cnt.sv
// stall_perf_cnt: free-running count of stalled cycles, wraps to zero, cleared only by reset.
module stall_perf_cnt
  import pipe_div_ctrl_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = en ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/pipe_div_ctrl.sv
// pipe_div_ctrl: MiniMIPS32 per-stage stall generator and DIV/DIVU sequencer.
// Defining STALL_CNT_EN adds the stall_cnt performance counter port.
module pipe_div_ctrl
  import pipe_div_ctrl_pkg::*;
#(
  parameter int HILO_W = 64,
  parameter int STALL_W = STALL_BUS
) (
  input  logic               cpu_clk_50M,
  input  logic               cpu_rst,
  input  logic               id_stallreq,
  input  logic               exe_div_req,
  input  logic               exe_div_signed,
  input  logic               flush,
  input  logic               div_ready,
  input  logic [HILO_W-1:0]  div_result,
  output logic               div_start,
  output logic               div_signed,
  output logic               div_annul,
  output logic [STALL_W-1:0] stall,
  output logic               exe_div_done,
  output logic [HILO_W-1:0]  div_hilo
`ifdef STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]   stall_cnt
`endif
);
  div_state_e state_q, state_d;
  logic div_start_q, div_start_d;
  logic div_signed_q, div_signed_d;
  logic div_annul_q, div_annul_d;
  logic exe_div_done_q, exe_div_done_d;
  logic [HILO_W-1:0] div_hilo_q, div_hilo_d;
  logic div_busy;
  always_comb begin
    state_d = state_q;
    div_start_d = 1'b0;
    div_signed_d = 1'b0;
    div_annul_d = 1'b0;
    exe_div_done_d = 1'b0;
    div_hilo_d = div_hilo_q;
    if (flush) begin
      state_d = DIV_IDLE;
      div_annul_d = state_q == DIV_RUN;
    end else begin
      case (state_q)
        DIV_IDLE: if (exe_div_req) begin
          state_d = DIV_RUN;
          div_start_d = 1'b1;
          div_signed_d = exe_div_signed;
        end
        DIV_RUN: if (div_ready) begin
          state_d = DIV_DONE;
          div_hilo_d = div_result;
          exe_div_done_d = 1'b1;
        end
        default: state_d = DIV_IDLE;
      endcase
    end
  end
  always_ff @(posedge cpu_clk_50M)
    if (cpu_rst) begin
      state_q <= DIV_IDLE;
      div_start_q <= 1'b0;
      div_signed_q <= 1'b0;
      div_annul_q <= 1'b0;
      exe_div_done_q <= 1'b0;
      div_hilo_q <= HILO_W'(ZERO_DWORD);
    end else begin
      state_q <= state_d;
      div_start_q <= div_start_d;
      div_signed_q <= div_signed_d;
      div_annul_q <= div_annul_d;
      exe_div_done_q <= exe_div_done_d;
      div_hilo_q <= div_hilo_d;
    end
  // DONE is excluded so the EXE/MEM register is released to capture div_hilo.
  assign div_busy = (state_q == DIV_IDLE && exe_div_req) || state_q == DIV_RUN;
  assign stall = (flush || cpu_rst) ? STALL_NONE : div_busy ? STALL_EXE : id_stallreq ? STALL_ID : STALL_NONE;
  assign div_start = div_start_q;
  assign div_signed = div_signed_q;
  assign div_annul = div_annul_q;
  assign exe_div_done = exe_div_done_q;
  assign div_hilo = div_hilo_q;
`ifdef STALL_CNT_EN
  stall_perf_cnt #(.W(CNT_W)) u_cnt (
    .clk(cpu_clk_50M),
    .rst(cpu_rst),
    .en (|stall),
    .cnt(stall_cnt)
  );
`endif
endmodule

// File: tb/tb_pipe_div_ctrl.sv
// tb_pipe_div_ctrl: directed bench for pipe_div_ctrl with a divider-result scoreboard.
module tb_pipe_div_ctrl;
  logic clk = 1'b0, rst = 1'b1, idst = 1'b0, req = 1'b0, sgn = 1'b0, flush = 1'b0, rdy = 1'b0;
  logic [63:0] res = '0;
  logic start, dsgn, annul, done;
  logic [4:0] stall;
  logic [63:0] hilo;
  logic [63:0] sb[$];
  logic [63:0] model_hilo = '0;
  int errors = 0, checks = 0;
  localparam logic [4:0] S_NONE = 5'b00000, S_ID = 5'b00011, S_EXE = 5'b00111;
`ifdef STALL_CNT_EN
  logic [31:0] scnt;
`endif
  always #5 clk = ~clk;
  pipe_div_ctrl dut (
    .cpu_clk_50M(clk),
    .cpu_rst(rst),
    .id_stallreq(idst),
    .exe_div_req(req),
    .exe_div_signed(sgn),
    .flush(flush),
    .div_ready(rdy),
    .div_result(res),
    .div_start(start),
    .div_signed(dsgn),
    .div_annul(annul),
    .stall(stall),
    .exe_div_done(done),
    .div_hilo(hilo)
`ifdef STALL_CNT_EN
    ,
    .stall_cnt(scnt)
`endif
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic expect_out(input string tag, input logic [4:0] st, input logic s, input logic sg,
                            input logic an, input logic dn);
    chk({tag, ".stall"}, 64'(stall), 64'(st));
    chk({tag, ".start"}, 64'(start), 64'(s));
    chk({tag, ".signed"}, 64'(dsgn), 64'(sg));
    chk({tag, ".annul"}, 64'(annul), 64'(an));
    chk({tag, ".done"}, 64'(done), 64'(dn));
    if (dn) begin
      if (sb.size() == 0) begin
        errors++;
        checks++;
        $error("FAIL %s.sb observed=empty expected=entry", tag);
      end else model_hilo = sb.pop_front();
    end
    chk({tag, ".hilo"}, hilo, model_hilo);
  endtask
  initial begin
    rst = 1'b1;
    req = 1'b1;
    sgn = 1'b1;
    repeat (2) begin
      tick();
      #1;
      expect_out("rst", S_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    rst = 1'b0;
    #1;
    expect_out("d1.c0", S_EXE, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    #1;
    expect_out("d1.c1", S_EXE, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int c = 2; c < 34; c++) begin
      tick();
      #1;
      expect_out("d1.run", S_EXE, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    tick();
    rdy = 1'b1;
    res = 64'h0000_0003_0000_0002;
    sb.push_back(res);
    #1;
    expect_out("d1.c34", S_EXE, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    rdy = 1'b0;
    #1;
    expect_out("d1.c35", S_NONE, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    req = 1'b0;
    sgn = 1'b0;
    rdy = 1'b1;
    res = 64'hdead_beef_dead_beef;
    #1;
    expect_out("d1.c36", S_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    rdy = 1'b0;
    #1;
    expect_out("idle_rdy", S_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    req = 1'b1;
    idst = 1'b1;
    #1;
    expect_out("d2.c0", S_EXE, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    #1;
    expect_out("d2.c1", S_EXE, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    #1;
    expect_out("d2.c2", S_EXE, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    rdy = 1'b1;
    res = 64'h1234_5678_9abc_def0;
    sb.push_back(res);
    #1;
    expect_out("d2.c3", S_EXE, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    rdy = 1'b0;
    #1;
    expect_out("d2.done", S_ID, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    req = 1'b0;
    #1;
    expect_out("d2.c5", S_ID, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    idst = 1'b0;
    #1;
    expect_out("d2.c6", S_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    req = 1'b1;
    sgn = 1'b1;
    #1;
    expect_out("fl.c0", S_EXE, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    #1;
    expect_out("fl.c1", S_EXE, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int c = 2; c < 10; c++) begin
      tick();
      #1;
      expect_out("fl.run", S_EXE, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    tick();
    flush = 1'b1;
    rdy = 1'b1;
    res = 64'h0bad_0bad_0bad_0bad;
    #1;
    expect_out("fl.c10", S_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    flush = 1'b0;
    rdy = 1'b0;
    req = 1'b0;
    sgn = 1'b0;
    #1;
    expect_out("fl.c11", S_NONE, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    #1;
    expect_out("fl.c12", S_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    req = 1'b1;
    flush = 1'b1;
    #1;
    expect_out("fli.c0", S_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    flush = 1'b0;
    req = 1'b0;
    #1;
    expect_out("fli.c1", S_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    req = 1'b1;
    #1;
    expect_out("b2b.c0", S_EXE, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int r = 0; r < 2; r++) begin
      tick();
      #1;
      expect_out("b2b.start", S_EXE, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (4) begin
        tick();
        #1;
        expect_out("b2b.run", S_EXE, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      tick();
      rdy = 1'b1;
      res = 64'h0000_0000_0000_1000 + 64'(r);
      sb.push_back(res);
      #1;
      expect_out("b2b.rdy", S_EXE, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      rdy = 1'b0;
      #1;
      expect_out("b2b.done", S_NONE, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      if (r == 1) req = 1'b0;
      #1;
      expect_out("b2b.after", r == 0 ? S_EXE : S_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
    end
`ifdef STALL_CNT_EN
    tick();
    force dut.u_cnt.cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.u_cnt.cnt_q;
    idst = 1'b1;
    tick();
    chk("cnt.0", 64'(scnt), 64'hFFFF_FFFF);
    tick();
    chk("cnt.1", 64'(scnt), 64'h0000_0000);
    tick();
    idst = 1'b0;
    chk("cnt.2", 64'(scnt), 64'h0000_0001);
`endif
    chk("sb.empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipe_div_ctrl.md
Name: pipe_div_ctrl

Overview:
- Pipeline controller for the 5-stage MiniMIPS32 core.
- Generates the per-stage stall vector that drives the PC, IF/ID, ID/EXE, EXE/MEM and MEM/WB registers.
- Sequences the multi-cycle divider used by DIV/DIVU: starts it, waits for it, and holds the 64-bit HI/LO result so the EXE/MEM register captures it on release.
- Also handles the load-use stall request from ID and the flush on exception.

Parameters:
- HILO_W, 64, divider result width (HI:LO).
- STALL_W, 5, stall vector width: [0] PC, [1] IF/ID, [2] ID/EXE, [3] EXE/MEM, [4] MEM/WB.
- CNT_W, 32, stall performance counter width (optional feature only).

Ports:
- cpu_clk_50M  in  1  core clock; all state updates on its rising edge.
- cpu_rst  in  1  reset, synchronous, active-high.
- id_stallreq  in  1  load-use hazard request from ID.
- exe_div_req  in  1  the instruction in EXE is DIV/DIVU.
- exe_div_signed  in  1  1 = DIV, 0 = DIVU.
- flush  in  1  exception flush; abandons in-flight work.
- div_ready  in  1  divider result valid, single-cycle pulse.
- div_result  in  HILO_W  divider quotient/remainder, valid with div_ready.
- div_start  out  1  one-cycle start pulse to the divider.
- div_signed  out  1  signedness to the divider, valid with div_start.
- div_annul  out  1  one-cycle abort pulse to the divider.
- stall  out  STALL_W  per-stage hold vector.
- exe_div_done  out  1  div_hilo is valid this cycle.
- div_hilo  out  HILO_W  latched divider result to EXE.
- stall_cnt  out  CNT_W  stalled-cycle count; present only with STALL_CNT_EN.

Behaviour:
- FSM states: IDLE, RUN, DONE.
- Reset (cpu_rst=1 at an edge): state=IDLE; div_start=0, div_signed=0, div_annul=0, exe_div_done=0, div_hilo=0, stall_cnt=0. Reset mid-RUN discards the divide without pulsing div_annul.
- IDLE:
  - exe_div_req=1 and flush=0 -> RUN next cycle.
  - On that transition, div_start=1 and div_signed=exe_div_signed are registered, so they are high during the first RUN cycle only.
- RUN:
  - div_ready=1 -> div_hilo<=div_result, exe_div_done<=1, next state DONE.
  - div_ready in the same cycle as div_start is legal and is accepted.
- DONE:
  - exe_div_done=1 for exactly one cycle; unconditional return to IDLE.
  - exe_div_req is still high in DONE (same instruction) and does not start a new divide.
- div_ready outside RUN is ignored.
- flush=1 in any state -> IDLE next cycle; exe_div_done<=0.
  - div_annul<=1 for one cycle only if the state was RUN.
  - flush has priority over div_ready in the same cycle; the result is dropped.
- div_hilo holds its value until the next div_ready accepted in RUN.
- Stall vector (combinational, priority order):
  - flush=1 -> 5'b00000.
  - div_busy = (IDLE and exe_div_req) or RUN -> 5'b00111 (hold PC, IF/ID, ID/EXE; EXE/MEM loads a bubble).
  - else id_stallreq -> 5'b00011 (hold PC, IF/ID; ID/EXE loads a bubble).
  - else 5'b00000.
  - DONE never produces a divider stall.
- Divide latency: request at cycle 0 -> stall from cycle 0; div_start in cycle 1; div_ready in cycle k -> DONE, stall released in cycle k+1; EXE/MEM captures at the end of cycle k+1.
- Back-to-back divides: a second DIV entering EXE after DONE sees IDLE with req and restarts normally.

Optional Feature:
- Macro STALL_CNT_EN.
- Defined:
  - stall_cnt port exists.
  - Increments by 1 each cycle stall!=0, wraps at 2^CNT_W-1 -> 0.
  - Cleared only by cpu_rst.
- Undefined: stall_cnt port and its counter are absent; all other behaviour is identical.

Decomposition:
- Shared defines file:
  - STALL_BUS width.
  - Stall encodings STALL_NONE=5'b00000, STALL_ID=5'b00011, STALL_EXE=5'b00111.
  - FSM state codes DIV_IDLE/DIV_RUN/DIV_DONE.
  - Existing ZERO_DWORD for the div_hilo reset value.
- One sub-module: stall_perf_cnt (the counter), instantiated only under STALL_CNT_EN.
- FSM and stall mux stay in pipe_div_ctrl.

Test Plan:
- Reset held 2 cycles while exe_div_req=1 -> all outputs 0, stall=00000, no div_start; after release, div_start in the 1st post-reset cycle+1.
- exe_div_req=1, signed=1 at cycle 0; div_ready with result 64'h0000_0003_0000_0002 at cycle 34 -> stall=00111 for cycles 0..34; div_start/div_signed=1 in cycle 1 only; cycle 35: exe_div_done=1, div_hilo=that value, stall=00000.
- id_stallreq=1 together with an active divide -> stall=00111; after DONE with id_stallreq still 1 -> stall=00011.
- flush at cycle 10 of RUN, div_ready also at cycle 10 -> cycle 11: IDLE, div_annul=1, exe_div_done=0, div_hilo unchanged; stall=00000 during cycle 10.
- Two DIVs back-to-back, div_ready 5 cycles after each start -> two div_start pulses, two single-cycle exe_div_done pulses, no extra start during either DONE.
- STALL_CNT_EN defined, counter preloaded near wrap via force to 32'hFFFF_FFFE, 3 stalled cycles -> reads FFFF_FFFF, 0000_0000, 0000_0001.
